// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single multiplexed external memory bus between the fetch port
// (instruction reads) and the data port (loads/stores). Each granted request
// runs a complete ADDR -> (WAIT x WAIT_CYCLES) -> DATA transaction. When both
// ports request in the same IDLE cycle, the port that was not granted last
// wins.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   f_req/f_addr/f_space  fetch request (level), address, 0=ROM 1=RAM
//   f_done/f_rdata        fetch completion pulse and fetched byte
//   d_req/d_we/d_addr/d_wdata/d_space
//                         data request (level), write enable, address,
//                         write data, 0=ROM 1=RAM
//   d_done/d_err/d_rdata  data completion pulse, ROM-write error pulse, read
//                         byte
//   bus_in                external read data
//   bus_out               address (address phase) or write data (data phase)
//   rom_ram               0=ROM 1=RAM select
//   addr_data             0=address phase, 1=data phase
//   bus_we                write strobe, data phase only
//   bus_active            high during ADDR/WAIT/DATA
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int BITS        = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            f_req,
    input  logic [BITS-1:0] f_addr,
    input  logic            f_space,
    output logic            f_done,
    output logic [BITS-1:0] f_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [BITS-1:0] d_addr,
    input  logic [BITS-1:0] d_wdata,
    input  logic            d_space,
    output logic            d_done,
    output logic            d_err,
    output logic [BITS-1:0] d_rdata,
    input  logic [BITS-1:0] bus_in,
    output logic [BITS-1:0] bus_out,
    output logic            rom_ram,
    output logic            addr_data,
    output logic            bus_we,
    output logic            bus_active
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    localparam logic       GNT_F     = 1'b0;
    localparam logic       GNT_D     = 1'b1;
    localparam logic       HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t          state_r, state_s;
    logic            grant_r, grant_s;
    logic            last_grant_r, last_grant_s;
    logic [BITS-1:0] addr_r, addr_s;
    logic [BITS-1:0] wdata_r, wdata_s;
    logic            space_r, space_s;
    logic            we_r, we_s;
    logic [3:0]      wait_cnt_r, wait_cnt_s;
    logic            pick_d_s;

    logic [BITS-1:0] bus_out_s;
    logic            rom_ram_s;
    logic            addr_data_s;
    logic            bus_we_s;
    logic            bus_active_s;

    logic            in_data_s;

    // Next-state, arbitration and request-field latching
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        space_s      = space_r;
        we_s         = we_r;
        wait_cnt_s   = wait_cnt_r;
        // Round-robin: on a tie, data wins only if fetch was granted last.
        pick_d_s     = d_req && (!f_req || (last_grant_r == GNT_F));

        case (state_r)
            ST_IDLE: begin
                if (f_req || d_req) begin
                    if (pick_d_s) begin
                        addr_s  = d_addr;
                        wdata_s = d_wdata;
                        space_s = d_space;
                        we_s    = d_we;
                        grant_s = GNT_D;
                    end else begin
                        addr_s  = f_addr;
                        wdata_s = {BITS{1'b0}};
                        space_s = f_space;
                        we_s    = 1'b0;
                        grant_s = GNT_F;
                    end
                    last_grant_s = grant_s;
                    state_s      = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (HAS_WAIT) begin
                    state_s    = ST_WAIT;
                    wait_cnt_s = WAIT_LOAD;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_WAIT: begin
                // Counter holds the number of WAIT cycles still to go, this one included.
                if (wait_cnt_r <= 4'd1) begin
                    state_s = ST_DATA;
                end else begin
                    wait_cnt_s = wait_cnt_r - 4'd1;
                end
            end
            ST_DATA: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Bus output decode for the upcoming cycle, so the outputs can be registered
    always_comb begin
        bus_out_s    = {BITS{1'b0}};
        rom_ram_s    = 1'b0;
        addr_data_s  = 1'b0;
        bus_we_s     = 1'b0;
        bus_active_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                bus_active_s = 1'b0;
            end
            ST_ADDR: begin
                bus_out_s    = addr_s;
                rom_ram_s    = space_s;
                bus_active_s = 1'b1;
            end
            ST_WAIT: begin
                bus_out_s    = we_s ? wdata_s : {BITS{1'b0}};
                rom_ram_s    = space_s;
                addr_data_s  = 1'b1;
                bus_active_s = 1'b1;
            end
            ST_DATA: begin
                bus_out_s    = we_s ? wdata_s : {BITS{1'b0}};
                rom_ram_s    = space_s;
                addr_data_s  = 1'b1;
                bus_active_s = 1'b1;
                // ROM is never strobed; the write is flagged as an error instead.
                bus_we_s     = we_s && space_s;
            end
            default: begin
                bus_active_s = 1'b0;
            end
        endcase
    end

    assign in_data_s = (state_r == ST_DATA);

    // State, grant, latched fields, wait counter and bus output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= GNT_F;
            last_grant_r <= GNT_D;
            addr_r       <= {BITS{1'b0}};
            wdata_r      <= {BITS{1'b0}};
            space_r      <= 1'b0;
            we_r         <= 1'b0;
            wait_cnt_r   <= 4'd0;
            bus_out      <= {BITS{1'b0}};
            rom_ram      <= 1'b0;
            addr_data    <= 1'b0;
            bus_we       <= 1'b0;
            bus_active   <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            space_r      <= space_s;
            we_r         <= we_s;
            wait_cnt_r   <= wait_cnt_s;
            bus_out      <= bus_out_s;
            rom_ram      <= rom_ram_s;
            addr_data    <= addr_data_s;
            bus_we       <= bus_we_s;
            bus_active   <= bus_active_s;
        end
    end

    // Completion pulses and read-data capture at the edge that ends DATA
    always_ff @(posedge clk) begin
        if (reset) begin
            f_done  <= 1'b0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;
            f_rdata <= {BITS{1'b0}};
            d_rdata <= {BITS{1'b0}};
        end else begin
            f_done <= in_data_s && (grant_r == GNT_F);
            d_done <= in_data_s && (grant_r == GNT_D);
            d_err  <= in_data_s && (grant_r == GNT_D) && we_r && !space_r;
            if (in_data_s && (grant_r == GNT_F)) begin
                f_rdata <= bus_in;
            end
            if (in_data_s && (grant_r == GNT_D) && !we_r) begin
                d_rdata <= bus_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Two arbiter instances (WAIT_CYCLES = 0 and 2) run side by side. A
// transaction-level reference model (phase = cycles since grant) predicts all
// outputs of both instances every cycle. On top of that: a table of single
// transactions with hand-computed expectations, contention, reset during a
// transaction, and a long randomized run.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]       reset_v, f_req_v, f_space_v, f_done_v;
    logic [NI-1:0]       d_req_v, d_we_v, d_space_v, d_done_v, d_err_v;
    logic [NI-1:0]       rom_ram_v, addr_data_v, bus_we_v, bus_active_v;
    logic [NI-1:0][7:0]  f_addr_v, f_rdata_v, d_addr_v, d_wdata_v, d_rdata_v;
    logic [NI-1:0][7:0]  bus_in_v, bus_out_v;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_bus_arbiter #(.BITS(8), .WAIT_CYCLES(2 * g)) u_dut (
            .clk(clk), .reset(reset_v[g]),
            .f_req(f_req_v[g]), .f_addr(f_addr_v[g]), .f_space(f_space_v[g]),
            .f_done(f_done_v[g]), .f_rdata(f_rdata_v[g]),
            .d_req(d_req_v[g]), .d_we(d_we_v[g]), .d_addr(d_addr_v[g]),
            .d_wdata(d_wdata_v[g]), .d_space(d_space_v[g]),
            .d_done(d_done_v[g]), .d_err(d_err_v[g]), .d_rdata(d_rdata_v[g]),
            .bus_in(bus_in_v[g]), .bus_out(bus_out_v[g]), .rom_ram(rom_ram_v[g]),
            .addr_data(addr_data_v[g]), .bus_we(bus_we_v[g]),
            .bus_active(bus_active_v[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model (per instance) ----------------
    // m_t: 0 = no transaction, 1 = address phase, 2..1+W = wait, 2+W = data.
    int         m_t     [NI];
    bit         m_port  [NI];   // 1 = data port owns the transaction
    bit         m_last  [NI];   // 1 = data port was granted last
    logic [7:0] m_addr  [NI];
    logic [7:0] m_wdata [NI];
    bit         m_space [NI];
    bit         m_we    [NI];
    bit         m_fdone [NI];
    bit         m_ddone [NI];
    bit         m_derr  [NI];
    logic [7:0] m_frd   [NI];
    logic [7:0] m_drd   [NI];

    function automatic int wc(int i);
        return 2 * i;
    endfunction

    function automatic logic [30:0] model_out(int i);
        logic [7:0] bo;
        logic       rr, ad, we, act;
        bo = 8'h00; rr = 1'b0; ad = 1'b0; we = 1'b0; act = 1'b0;
        if (m_t[i] == 1) begin
            bo = m_addr[i]; rr = m_space[i]; act = 1'b1;
        end else if (m_t[i] >= 2) begin
            rr = m_space[i]; ad = 1'b1; act = 1'b1;
            if (m_we[i]) bo = m_wdata[i];
            if (m_t[i] == 2 + wc(i) && m_we[i] && m_space[i]) we = 1'b1;
        end
        return {bo, rr, ad, we, act, m_fdone[i], m_frd[i], m_ddone[i], m_derr[i], m_drd[i]};
    endfunction

    function automatic logic [30:0] dut_out(int i);
        return {bus_out_v[i], rom_ram_v[i], addr_data_v[i], bus_we_v[i], bus_active_v[i],
                f_done_v[i], f_rdata_v[i], d_done_v[i], d_err_v[i], d_rdata_v[i]};
    endfunction

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step(int i);
        bit in_data, pick_d;
        in_data = (m_t[i] == 2 + wc(i));
        if (reset_v[i]) begin
            m_t[i] = 0; m_last[i] = 1'b1;
            m_fdone[i] = 1'b0; m_ddone[i] = 1'b0; m_derr[i] = 1'b0;
            m_frd[i] = 8'h00; m_drd[i] = 8'h00;
            return;
        end
        m_fdone[i] = in_data && !m_port[i];
        m_ddone[i] = in_data && m_port[i];
        m_derr[i]  = in_data && m_port[i] && m_we[i] && !m_space[i];
        if (in_data && !m_we[i]) begin
            if (m_port[i]) m_drd[i] = bus_in_v[i];
            else           m_frd[i] = bus_in_v[i];
        end
        if (in_data) begin
            m_t[i] = 0;
        end else if (m_t[i] != 0) begin
            m_t[i] = m_t[i] + 1;
        end else if (f_req_v[i] || d_req_v[i]) begin
            pick_d = d_req_v[i] && (!f_req_v[i] || !m_last[i]);
            m_port[i] = pick_d;
            m_last[i] = pick_d;
            if (pick_d) begin
                m_addr[i] = d_addr_v[i]; m_wdata[i] = d_wdata_v[i];
                m_space[i] = d_space_v[i]; m_we[i] = d_we_v[i];
            end else begin
                m_addr[i] = f_addr_v[i]; m_wdata[i] = 8'h00;
                m_space[i] = f_space_v[i]; m_we[i] = 1'b0;
            end
            m_t[i] = 1;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: model consumes current inputs, then outputs are compared
    // against the model half a period after the edge.
    task automatic tick();
        for (int i = 0; i < NI; i++) model_step(i);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("model_i%0d", i), {1'b0, dut_out(i)}, {1'b0, model_out(i)});
        end
    endtask

    task automatic idle_inputs();
        reset_v = '0; f_req_v = '0; d_req_v = '0; d_we_v = '0;
        f_space_v = '0; d_space_v = '0; f_addr_v = '0; d_addr_v = '0;
        d_wdata_v = '0; bus_in_v = '0;
    endtask

    // ---------------- table of single transactions ----------------
    typedef struct {
        bit         port_d;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         space;
        logic [7:0] bin;
        logic [7:0] exp_dbus;
        bit         exp_we;
        bit         exp_err;
        bit         chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(int i, vec_t v);
        int w;
        w = wc(i);
        if (v.port_d) begin
            d_req_v[i] = 1'b1; d_we_v[i] = v.we; d_addr_v[i] = v.addr;
            d_wdata_v[i] = v.wdata; d_space_v[i] = v.space;
        end else begin
            f_req_v[i] = 1'b1; f_addr_v[i] = v.addr; f_space_v[i] = v.space;
        end
        bus_in_v[i] = ~v.bin;
        tick();
        chk("addr_phase", {bus_out_v[i], addr_data_v[i], rom_ram_v[i], bus_active_v[i], bus_we_v[i]},
            {v.addr, 1'b0, v.space, 1'b1, 1'b0});
        // Changes after the grant must be ignored.
        f_addr_v[i] = ~v.addr; d_addr_v[i] = ~v.addr; d_wdata_v[i] = ~v.wdata;
        f_space_v[i] = ~v.space; d_space_v[i] = ~v.space; d_we_v[i] = ~v.we;
        for (int k = 0; k < w; k++) begin
            tick();
            chk("wait_phase", {addr_data_v[i], bus_we_v[i], bus_active_v[i], rom_ram_v[i]},
                {1'b1, 1'b0, 1'b1, v.space});
        end
        tick();
        chk("data_phase", {bus_out_v[i], addr_data_v[i], rom_ram_v[i], bus_we_v[i]},
            {v.exp_dbus, 1'b1, v.space, v.exp_we});
        chk("no_early_done", {f_done_v[i], d_done_v[i]}, 2'b00);
        bus_in_v[i] = v.bin;
        f_req_v[i] = 1'b0; d_req_v[i] = 1'b0;
        tick();
        chk("done", {f_done_v[i], d_done_v[i], d_err_v[i], bus_active_v[i]},
            {!v.port_d, v.port_d, v.exp_err, 1'b0});
        if (v.chk_rd) chk("rdata", v.port_d ? d_rdata_v[i] : f_rdata_v[i], v.exp_rd);
        bus_in_v[i] = 8'h00;
        tick();
        chk("done_one_cycle", {f_done_v[i], d_done_v[i], d_err_v[i]}, 3'b000);
    endtask

    initial begin
        //          port we  addr   wdata  sp bin    dbus   we err rd exp
        vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 8'h40, 8'h3C, 1'b1, 8'h77, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 8'h22, 8'h99, 1'b0, 8'h11, 8'h99, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A};
        vecs[4] = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF};

        // Reset, two cycles.
        idle_inputs();
        reset_v = '1;
        tick();
        tick();
        for (int i = 0; i < NI; i++) chk("reset_state", {1'b0, dut_out(i)}, 32'h0);
        reset_v = '0;
        tick();

        // Table of single transactions on both instances.
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 6; n++) run_vec(i, vecs[n]);
        end

        // Contention after a fresh reset: fetch first, then strict alternation.
        reset_v = '1;
        tick();
        reset_v = '0;
        f_req_v = '1; d_req_v = '1;
        f_addr_v = {8'h31, 8'h30}; d_addr_v = {8'h51, 8'h50};
        f_space_v = '1; d_space_v = '1;
        for (int k = 1; k <= 24; k++) begin
            bus_in_v = {8'(k), 8'(k + 100)};
            tick();
            for (int i = 0; i < NI; i++) begin
                int p;
                p = 3 + wc(i);
                chk("contend_f", f_done_v[i], ((k % p) == 0) && (((k / p) % 2) == 1));
                chk("contend_d", d_done_v[i], ((k % p) == 0) && (((k / p) % 2) == 0));
            end
        end
        idle_inputs();
        repeat (6) tick();

        // Reset while instance 0 is in DATA: no done, everything zero.
        f_req_v = '1; f_addr_v = {8'h66, 8'h66}; f_space_v = '1;
        tick();
        tick();
        chk("pre_reset_in_data", addr_data_v[0], 1'b1);
        reset_v = '1;
        f_req_v = '0;
        tick();
        for (int i = 0; i < NI; i++) chk("reset_abort", {1'b0, dut_out(i)}, 32'h0);
        reset_v = '0;
        tick();
        chk("no_done_after_abort", {f_done_v[0], d_done_v[0]}, 2'b00);
        // First tie after reset goes to fetch.
        f_req_v = 2'b01; d_req_v = 2'b01;
        tick();
        tick();
        tick();
        chk("tie_after_reset", {f_done_v[0], d_done_v[0]}, 2'b10);
        idle_inputs();
        repeat (8) tick();

        // Randomized run against the model.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NI; i++) begin
                reset_v[i]   = ($urandom_range(0, 99) == 0);
                f_req_v[i]   = ($urandom_range(0, 3) != 0);
                d_req_v[i]   = ($urandom_range(0, 3) != 0);
                d_we_v[i]    = 1'($urandom);
                f_space_v[i] = 1'($urandom);
                d_space_v[i] = 1'($urandom);
                f_addr_v[i]  = 8'($urandom);
                d_addr_v[i]  = 8'($urandom);
                d_wdata_v[i] = 8'($urandom);
                bus_in_v[i]  = 8'($urandom);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
